// File: rtl/cntr8_fsm_pkg.sv
// Shared definitions for the cntr8_fsm counter: datapath width, adder step
// constants and the FSM state encoding.
package cntr8_fsm_pkg;

    localparam int unsigned Width = 8;

    // Adder B operand for the two counting directions (0xFF is -1 mod 256).
    localparam logic [Width-1:0] StepUp   = 8'h01;
    localparam logic [Width-1:0] StepDown = 8'hFF;

    // Codes 3'b110 and 3'b111 are unused; the FSM treats them as IDLE.
    typedef enum logic [2:0] {
        StIdle = 3'b000,
        StLoad = 3'b001,
        StInc  = 3'b010,
        StInc2 = 3'b011,
        StDec  = 3'b100,
        StDec2 = 3'b101
    } state_e;

endpackage

// File: rtl/cntr8_fsm_if.sv
// Control/data bundle of the cntr8_fsm counter.
//   en, load, inc  : advance, load request and direction controls
//   d_in           : load value
//   d_out          : registered count
//   o_state        : registered FSM state code
//   wrap           : registered one-cycle wrap flag
// master drives the controls and observes the outputs; slave is the counter.
interface cntr8_fsm_if;
    import cntr8_fsm_pkg::*;

    logic             en;
    logic             load;
    logic             inc;
    logic [Width-1:0] d_in;
    logic [Width-1:0] d_out;
    logic [2:0]       o_state;
    logic             wrap;

    modport master (
        output en, load, inc, d_in,
        input  d_out, o_state, wrap
    );

    modport slave (
        input  en, load, inc, d_in,
        output d_out, o_state, wrap
    );

endinterface

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice.
//   a, b : operands
//   ci   : carry in
//   s    : sum
//   co   : carry out
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] p;
    logic [3:0] g;
    logic [4:0] c;

    assign p = a ^ b;
    assign g = a & b;

    // Every carry is formed directly from generate/propagate terms.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s  = p ^ c[3:0];
    assign co = c[4];

endmodule

// File: rtl/cla8.sv
// 8-bit adder built from two chained 4-bit carry-lookahead slices.
//   a, b : operands
//   ci   : carry in
//   s    : sum (mod 256)
//   co   : carry out of bit 7
module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic c_mid;

    cla4 u_lo (
        .a  (a[3:0]),
        .b  (b[3:0]),
        .ci (ci),
        .s  (s[3:0]),
        .co (c_mid)
    );

    cla4 u_hi (
        .a  (a[7:4]),
        .b  (b[7:4]),
        .ci (c_mid),
        .s  (s[7:4]),
        .co (co)
    );

endmodule

// File: rtl/cntr8_fsm.sv
// 8-bit loadable up/down counter sequenced by a 6-state FSM.
//   clk   : rising-edge clock
//   reset : synchronous active-high reset
//   bus   : slave side of cntr8_fsm_if (en/load/inc/d_in in, d_out/o_state/wrap out)
// All outputs come straight from flops.
module cntr8_fsm
    import cntr8_fsm_pkg::*;
(
    input logic        clk,
    input logic        reset,
    cntr8_fsm_if.slave bus
);

    state_e           state_q, state_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    logic [Width-1:0] sum;
    logic             co;

    // Adding 0xFF is a decrement; a missing carry then means 00 -> FF.
    cla8 u_cla8 (
        .a  (cnt_q),
        .b  (bus.inc ? StepUp : StepDown),
        .ci (1'b0),
        .s  (sum),
        .co (co)
    );

    // ns_logic
    always_comb begin
        state_d = StIdle;
        unique case (state_q)
            StIdle, StLoad, StInc, StInc2, StDec, StDec2: begin
                if (bus.load) begin
                    state_d = StLoad;
                end else if (bus.inc) begin
                    state_d = (state_q == StInc) ? StInc2 : StInc;
                end else begin
                    state_d = (state_q == StDec) ? StDec2 : StDec;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // os_logic: count and wrap follow the state being entered.
    always_comb begin
        cnt_d  = '0;
        wrap_d = 1'b0;
        unique case (state_d)
            StLoad: begin
                cnt_d = bus.d_in;
            end
            StInc, StInc2: begin
                cnt_d  = sum;
                wrap_d = co;
            end
            StDec, StDec2: begin
                cnt_d  = sum;
                wrap_d = ~co;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            wrap_q  <= 1'b0;
        end else if (bus.en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wrap_q  <= wrap_d;
        end else begin
            wrap_q  <= 1'b0;
        end
    end

    assign bus.d_out   = cnt_q;
    assign bus.o_state = state_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: tb/tb_cntr8_fsm.sv
// Self-checking bench for cntr8_fsm: a directed vector table, a hand-written
// reset-mid-count sequence and a randomized run against an arithmetic model.
module tb_cntr8_fsm;

    logic clk;
    logic reset;

    cntr8_fsm_if bus ();

    cntr8_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;

    // Reference model: count as an integer, state as the documented code.
    int m_cnt;
    int m_st;
    int m_wrap;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic       inc;
        logic [7:0] din;
        logic [7:0] exp_dout;
        logic [2:0] exp_state;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[$];

    function automatic void model_edge(input logic rst, input logic en, input logic ld,
                                       input logic up, input logic [7:0] din);
        if (rst) begin
            m_st = 0; m_cnt = 0; m_wrap = 0;
        end else if (!en) begin
            m_wrap = 0;
        end else if (ld) begin
            m_st = 1; m_cnt = int'(din); m_wrap = 0;
        end else if (up) begin
            m_st   = (m_st == 2) ? 3 : 2;
            m_wrap = (m_cnt == 255) ? 1 : 0;
            m_cnt  = (m_cnt + 1) % 256;
        end else begin
            m_st   = (m_st == 4) ? 5 : 4;
            m_wrap = (m_cnt == 0) ? 1 : 0;
            m_cnt  = (m_cnt + 255) % 256;
        end
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one edge's inputs, clock, advance the model, then settle.
    task automatic step(input logic rst, input logic en, input logic ld, input logic up,
                        input logic [7:0] din);
        reset    = rst;
        bus.en   = en;
        bus.load = ld;
        bus.inc  = up;
        bus.d_in = din;
        @(posedge clk);
        model_edge(rst, en, ld, up, din);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " d_out"},   {24'd0, bus.d_out},   32'(m_cnt));
        check({tag, " o_state"}, {29'd0, bus.o_state}, 32'(m_st));
        check({tag, " wrap"},    {31'd0, bus.wrap},    32'(m_wrap));
    endtask

    function automatic void add(input logic rst, input logic en, input logic ld, input logic up,
                                input logic [7:0] din, input logic [7:0] ed,
                                input logic [2:0] es, input logic ew);
        vec_t v;
        v.rst = rst; v.en = en; v.load = ld; v.inc = up; v.din = din;
        v.exp_dout = ed; v.exp_state = es; v.exp_wrap = ew;
        vecs.push_back(v);
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        m_cnt = 0; m_st = 0; m_wrap = 0;
        reset    = 1'b1;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.inc  = 1'b0;
        bus.d_in = 8'h00;

        //   rst en ld inc din    d_out  state   wrap
        add(1, 0, 1, 0, 8'hAA, 8'h00, 3'b000, 0);  // reset with load pending
        add(1, 0, 1, 0, 8'hAA, 8'h00, 3'b000, 0);
        add(0, 1, 0, 0, 8'h00, 8'hFF, 3'b100, 1);  // DEC out of IDLE at 00 wraps
        add(0, 0, 0, 0, 8'h00, 8'hFF, 3'b100, 0);  // hold clears wrap
        add(0, 1, 1, 0, 8'h3C, 8'h3C, 3'b001, 0);
        add(0, 1, 0, 1, 8'h00, 8'h3D, 3'b010, 0);
        add(0, 1, 0, 1, 8'h00, 8'h3E, 3'b011, 0);
        add(0, 1, 0, 1, 8'h00, 8'h3F, 3'b010, 0);
        add(0, 1, 1, 0, 8'hFE, 8'hFE, 3'b001, 0);
        add(0, 1, 0, 1, 8'h00, 8'hFF, 3'b010, 0);
        add(0, 1, 0, 1, 8'h00, 8'h00, 3'b011, 1);  // FF -> 00
        add(0, 1, 0, 1, 8'h00, 8'h01, 3'b010, 0);
        add(0, 1, 1, 0, 8'h01, 8'h01, 3'b001, 0);
        add(0, 1, 0, 0, 8'h00, 8'h00, 3'b100, 0);
        add(0, 1, 0, 0, 8'h00, 8'hFF, 3'b101, 1);  // 00 -> FF
        add(0, 1, 0, 0, 8'h00, 8'hFE, 3'b100, 0);
        add(0, 1, 1, 0, 8'h0F, 8'h0F, 3'b001, 0);
        add(0, 1, 0, 1, 8'h00, 8'h10, 3'b010, 0);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 0, 8'h77, 8'h10, 3'b010, 0);
        add(0, 1, 0, 1, 8'h00, 8'h11, 3'b011, 0);
        add(0, 1, 1, 1, 8'h55, 8'h55, 3'b001, 0);  // load beats inc
        add(0, 1, 0, 1, 8'h00, 8'h56, 3'b010, 0);
        add(1, 0, 0, 1, 8'h00, 8'h00, 3'b000, 0);  // reset while holding

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].inc, vecs[i].din);
            check($sformatf("vec%0d d_out", i),   {24'd0, bus.d_out},   {24'd0, vecs[i].exp_dout});
            check($sformatf("vec%0d o_state", i), {29'd0, bus.o_state}, {29'd0, vecs[i].exp_state});
            check($sformatf("vec%0d wrap", i),    {31'd0, bus.wrap},    {31'd0, vecs[i].exp_wrap});
        end

        // Reset mid-count, just after a wrap, with every other control active.
        step(0, 1, 1, 0, 8'hFF);
        step(0, 1, 0, 1, 8'h00);
        check("pre-reset wrap", {31'd0, bus.wrap}, 32'd1);
        step(1, 1, 1, 1, 8'hC3);
        check("mid reset d_out",   {24'd0, bus.d_out},   32'h00);
        check("mid reset o_state", {29'd0, bus.o_state}, 32'd0);
        check("mid reset wrap",    {31'd0, bus.wrap},    32'd0);

        // Randomized run against the model, compared every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic r_rst, r_en, r_ld, r_up;
            logic [7:0] r_din;
            r_rst = ($urandom_range(0, 31) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            r_ld  = ($urandom_range(0, 9) == 0);
            r_up  = $urandom_range(0, 1) == 1;
            r_din = 8'($urandom);
            // Bias loads toward the wrap boundaries.
            if ($urandom_range(0, 3) == 0) r_din = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
            step(r_rst, r_en, r_ld, r_up, r_din);
            check_model($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
